id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/rv32im_pkg.sv | 50 +++++
 rtl/id_ex_stage_if.sv | 75 +++++++
 rtl/forward_unit.sv | 49 ++++
 rtl/id_ex_stage.sv | 186 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32im_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32im_pkg
//  Description : Shared RV32IM decode/execute definitions: ALU operation
//                encodings, forwarding source enum, register index helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32im_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALU_SEL_W  = 5;

  // ALU operation codes carried from decode to execute.
  typedef enum logic [ALU_SEL_W-1:0] {
    ALU_ADD    = 5'b00000,
    ALU_MUL    = 5'b00001,
    ALU_SUB    = 5'b00010,
    ALU_SLL    = 5'b00100,
    ALU_MULH   = 5'b00101,
    ALU_SLT    = 5'b01000,
    ALU_MULHSU = 5'b01001,
    ALU_SLTU   = 5'b01100,
    ALU_MULHU  = 5'b01101,
    ALU_XOR    = 5'b10000,
    ALU_DIV    = 5'b10001,
    ALU_SRL    = 5'b10100,
    ALU_DIVU   = 5'b10101,
    ALU_SRA    = 5'b10110,
    ALU_OR     = 5'b11000,
    ALU_REM    = 5'b11001,
    ALU_AND    = 5'b11100,
    ALU_REMU   = 5'b11101
  } alu_sel_e;

  // Where an execute-stage source operand is taken from.
  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_src_e;

  // True when a writer targeting dst produces the register read as src.
  // x0 is hard-wired to zero, so it never matches.
  function automatic logic addr_match(input logic [REG_ADDR_W-1:0] dst,
                                      input logic [REG_ADDR_W-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage_if
//  Description : Bundle of decode inputs, bypass sources, pipeline control
//                and execute-stage outputs of the ID/EX pipeline register.
//  Ports       : master - upstream/downstream pipeline side
//                slave  - the id_ex_stage itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if
  import rv32im_pkg::*;
#(
  parameter int XLEN = 32
);
  // Decode slot
  logic                  ID_VALID;
  logic [XLEN-1:0]       ID_PC;
  logic [XLEN-1:0]       ID_RS1_DATA;
  logic [XLEN-1:0]       ID_RS2_DATA;
  logic [XLEN-1:0]       ID_IMM;
  logic [REG_ADDR_W-1:0] ID_RS1_ADDR;
  logic [REG_ADDR_W-1:0] ID_RS2_ADDR;
  logic [REG_ADDR_W-1:0] ID_RD_ADDR;
  logic [ALU_SEL_W-1:0]  ID_ALU_SELECT;
  logic                  ID_OP1_PC;
  logic                  ID_OP2_IMM;
  logic                  ID_MEM_READ;
  logic                  ID_MEM_WRITE;
  logic                  ID_REG_WRITE;
  // Bypass sources
  logic [REG_ADDR_W-1:0] MEM_RD_ADDR;
  logic                  MEM_REG_WRITE;
  logic [XLEN-1:0]       MEM_RESULT;
  logic [REG_ADDR_W-1:0] WB_RD_ADDR;
  logic                  WB_REG_WRITE;
  logic [XLEN-1:0]       WB_RESULT;
  // Pipeline control
  logic                  FLUSH;
  logic                  HOLD;
  // Execute stage outputs
  logic [XLEN-1:0]       DATA1;
  logic [XLEN-1:0]       DATA2;
  logic [ALU_SEL_W-1:0]  SELECT;
  logic                  EX_VALID;
  logic                  EX_MEM_READ;
  logic                  EX_MEM_WRITE;
  logic                  EX_REG_WRITE;
  logic [REG_ADDR_W-1:0] EX_RD_ADDR;
  logic [XLEN-1:0]       EX_PC;
  logic [XLEN-1:0]       EX_STORE_DATA;
  logic                  STALL;
  logic [31:0]           BUBBLE_COUNT;

  modport master (
    output ID_VALID, ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM,
           ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR, ID_ALU_SELECT,
           ID_OP1_PC, ID_OP2_IMM, ID_MEM_READ, ID_MEM_WRITE, ID_REG_WRITE,
           MEM_RD_ADDR, MEM_REG_WRITE, MEM_RESULT,
           WB_RD_ADDR, WB_REG_WRITE, WB_RESULT, FLUSH, HOLD,
    input  DATA1, DATA2, SELECT, EX_VALID, EX_MEM_READ, EX_MEM_WRITE,
           EX_REG_WRITE, EX_RD_ADDR, EX_PC, EX_STORE_DATA, STALL, BUBBLE_COUNT
  );

  modport slave (
    input  ID_VALID, ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM,
           ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR, ID_ALU_SELECT,
           ID_OP1_PC, ID_OP2_IMM, ID_MEM_READ, ID_MEM_WRITE, ID_REG_WRITE,
           MEM_RD_ADDR, MEM_REG_WRITE, MEM_RESULT,
           WB_RD_ADDR, WB_REG_WRITE, WB_RESULT, FLUSH, HOLD,
    output DATA1, DATA2, SELECT, EX_VALID, EX_MEM_READ, EX_MEM_WRITE,
           EX_REG_WRITE, EX_RD_ADDR, EX_PC, EX_STORE_DATA, STALL, BUBBLE_COUNT
  );

endinterface
`default_nettype wire

// File: rtl/forward_unit.sv
`default_nettype none
// ============================================================================
//  Module      : forward_unit
//  Description : Selects the freshest value of one source register from the
//                EX/MEM result, the MEM/WB result or the registered read data.
//  Ports       : rs_addr/reg_data        - operand index and register value
//                mem_* / wb_*            - bypass sources
//                fwd_data                - resolved operand value
//  Revision    : 1.0 - initial release
// ============================================================================
module forward_unit
  import rv32im_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [XLEN-1:0]       reg_data,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic                  mem_reg_write,
  input  logic [XLEN-1:0]       mem_result,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic                  wb_reg_write,
  input  logic [XLEN-1:0]       wb_result,
  output logic [XLEN-1:0]       fwd_data
);

  fwd_src_e fwd_src;

  // The MEM stage holds the younger result, so it is checked first.
  always_comb begin
    fwd_src = FWD_REG;
    if (mem_reg_write && addr_match(mem_rd_addr, rs_addr)) begin
      fwd_src = FWD_MEM;
    end else if (wb_reg_write && addr_match(wb_rd_addr, rs_addr)) begin
      fwd_src = FWD_WB;
    end
  end

  always_comb begin
    fwd_data = reg_data;
    case (fwd_src)
      FWD_MEM: fwd_data = mem_result;
      FWD_WB:  fwd_data = wb_result;
      default: fwd_data = reg_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register with load-use hazard detection,
//                bubble insertion, flush/hold control and operand bypassing.
//  Ports       : CLK, RESET  - clock, synchronous active-high reset
//                bus (slave) - decode inputs, bypass sources, FLUSH/HOLD,
//                              ALU operands, EX control, STALL, BUBBLE_COUNT
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
  import rv32im_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic         CLK,
  input  logic         RESET,
  id_ex_stage_if.slave bus
);

  logic                  valid_q,        valid_d;
  logic                  mem_read_q,     mem_read_d;
  logic                  mem_write_q,    mem_write_d;
  logic                  reg_write_q,    reg_write_d;
  logic                  op1_pc_q,       op1_pc_d;
  logic                  op2_imm_q,      op2_imm_d;
  logic [ALU_SEL_W-1:0]  select_q,       select_d;
  logic [REG_ADDR_W-1:0] rd_addr_q,      rd_addr_d;
  logic [REG_ADDR_W-1:0] rs1_addr_q,     rs1_addr_d;
  logic [REG_ADDR_W-1:0] rs2_addr_q,     rs2_addr_d;
  logic [XLEN-1:0]       pc_q,           pc_d;
  logic [XLEN-1:0]       rs1_data_q,     rs1_data_d;
  logic [XLEN-1:0]       rs2_data_q,     rs2_data_d;
  logic [XLEN-1:0]       imm_q,          imm_d;
  logic [31:0]           bubble_count_q, bubble_count_d;

  logic                  stall;
  logic                  capture;
  logic                  bubble;
  logic [XLEN-1:0]       rs1_fwd;
  logic [XLEN-1:0]       rs2_fwd;

  // A load in EX cannot supply its data to the instruction behind it in time,
  // so decode must wait one cycle. A flush kills decode, so no wait is needed.
  always_comb begin
    stall = valid_q && mem_read_q && bus.ID_VALID && !bus.FLUSH &&
            (addr_match(rd_addr_q, bus.ID_RS1_ADDR) ||
             addr_match(rd_addr_q, bus.ID_RS2_ADDR));
  end

  // Edge priority below RESET: FLUSH, HOLD, STALL, then normal capture.
  always_comb begin
    capture = 1'b0;
    bubble  = 1'b0;
    bubble_count_d = bubble_count_q;
    if (bus.FLUSH) begin
      bubble = 1'b1;
    end else if (bus.HOLD) begin
      bubble = 1'b0;
    end else if (stall) begin
      bubble = 1'b1;
      bubble_count_d = bubble_count_q + 32'd1;
    end else begin
      capture = 1'b1;
    end
  end

  always_comb begin
    valid_d     = valid_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    reg_write_d = reg_write_q;
    op1_pc_d    = op1_pc_q;
    op2_imm_d   = op2_imm_q;
    select_d    = select_q;
    rd_addr_d   = rd_addr_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    pc_d        = pc_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    if (capture) begin
      // An empty decode slot enters EX as a bubble: control masked off.
      valid_d     = bus.ID_VALID;
      mem_read_d  = bus.ID_MEM_READ  && bus.ID_VALID;
      mem_write_d = bus.ID_MEM_WRITE && bus.ID_VALID;
      reg_write_d = bus.ID_REG_WRITE && bus.ID_VALID;
      select_d    = bus.ID_VALID ? bus.ID_ALU_SELECT : ALU_ADD;
      rd_addr_d   = bus.ID_VALID ? bus.ID_RD_ADDR : '0;
      op1_pc_d    = bus.ID_OP1_PC;
      op2_imm_d   = bus.ID_OP2_IMM;
      rs1_addr_d  = bus.ID_RS1_ADDR;
      rs2_addr_d  = bus.ID_RS2_ADDR;
      pc_d        = bus.ID_PC;
      rs1_data_d  = bus.ID_RS1_DATA;
      rs2_data_d  = bus.ID_RS2_DATA;
      imm_d       = bus.ID_IMM;
    end else if (bubble) begin
      // Data fields of a bubble are meaningless and simply left as they were.
      valid_d     = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      reg_write_d = 1'b0;
      select_d    = ALU_ADD;
      rd_addr_d   = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q        <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      reg_write_q    <= 1'b0;
      op1_pc_q       <= 1'b0;
      op2_imm_q      <= 1'b0;
      select_q       <= ALU_ADD;
      rd_addr_q      <= '0;
      rs1_addr_q     <= '0;
      rs2_addr_q     <= '0;
      pc_q           <= '0;
      rs1_data_q     <= '0;
      rs2_data_q     <= '0;
      imm_q          <= '0;
      bubble_count_q <= '0;
    end else begin
      valid_q        <= valid_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      reg_write_q    <= reg_write_d;
      op1_pc_q       <= op1_pc_d;
      op2_imm_q      <= op2_imm_d;
      select_q       <= select_d;
      rd_addr_q      <= rd_addr_d;
      rs1_addr_q     <= rs1_addr_d;
      rs2_addr_q     <= rs2_addr_d;
      pc_q           <= pc_d;
      rs1_data_q     <= rs1_data_d;
      rs2_data_q     <= rs2_data_d;
      imm_q          <= imm_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  // Bypass is resolved after the register so late MEM/WB results, including
  // those arriving while the stage is held, reach the ALU operands.
  forward_unit #(.XLEN(XLEN)) u_fwd_rs1 (
    .rs_addr       (rs1_addr_q),
    .reg_data      (rs1_data_q),
    .mem_rd_addr   (bus.MEM_RD_ADDR),
    .mem_reg_write (bus.MEM_REG_WRITE),
    .mem_result    (bus.MEM_RESULT),
    .wb_rd_addr    (bus.WB_RD_ADDR),
    .wb_reg_write  (bus.WB_REG_WRITE),
    .wb_result     (bus.WB_RESULT),
    .fwd_data      (rs1_fwd)
  );

  forward_unit #(.XLEN(XLEN)) u_fwd_rs2 (
    .rs_addr       (rs2_addr_q),
    .reg_data      (rs2_data_q),
    .mem_rd_addr   (bus.MEM_RD_ADDR),
    .mem_reg_write (bus.MEM_REG_WRITE),
    .mem_result    (bus.MEM_RESULT),
    .wb_rd_addr    (bus.WB_RD_ADDR),
    .wb_reg_write  (bus.WB_REG_WRITE),
    .wb_result     (bus.WB_RESULT),
    .fwd_data      (rs2_fwd)
  );

  assign bus.DATA1         = op1_pc_q  ? pc_q  : rs1_fwd;
  assign bus.DATA2         = op2_imm_q ? imm_q : rs2_fwd;
  assign bus.EX_STORE_DATA = rs2_fwd;
  assign bus.SELECT        = select_q;
  assign bus.EX_VALID      = valid_q;
  assign bus.EX_MEM_READ   = mem_read_q;
  assign bus.EX_MEM_WRITE  = mem_write_q;
  assign bus.EX_REG_WRITE  = reg_write_q;
  assign bus.EX_RD_ADDR    = rd_addr_q;
  assign bus.EX_PC         = pc_q;
  assign bus.STALL         = stall;
  assign bus.BUBBLE_COUNT  = bubble_count_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage with a reference model
//                of the instruction held in EX and the bubble counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
  import rv32im_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(XLEN)) bus ();

  id_ex_stage #(.XLEN(XLEN)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: the instruction currently sitting in EX.
  typedef struct {
    bit        valid, ld, st, we, op1pc, op2imm;
    bit [4:0]  sel, rd, rs1, rs2;
    bit [31:0] pc, a, b, imm;
  } instr_t;

  instr_t    ex;
  bit [31:0] bcount;

  function automatic bit [31:0] fwd(input bit [4:0] r, input bit [31:0] regv);
    if (r == 0) return regv;
    if (bus.MEM_REG_WRITE && bus.MEM_RD_ADDR == r) return bus.MEM_RESULT;
    if (bus.WB_REG_WRITE && bus.WB_RD_ADDR == r) return bus.WB_RESULT;
    return regv;
  endfunction

  function automatic bit exp_stall();
    return ex.valid && ex.ld && bus.ID_VALID && !bus.FLUSH && ex.rd != 0 &&
           (ex.rd == bus.ID_RS1_ADDR || ex.rd == bus.ID_RS2_ADDR);
  endfunction

  function automatic bit [31:0] exp_d1();
    return ex.op1pc ? ex.pc : fwd(ex.rs1, ex.a);
  endfunction

  function automatic bit [31:0] exp_d2();
    return ex.op2imm ? ex.imm : fwd(ex.rs2, ex.b);
  endfunction

  // Advance one clock edge; the model consumes the inputs seen just before it.
  task automatic cycle();
    instr_t nxt;
    bit     hz;
    hz  = exp_stall();
    nxt = ex;
    if (rst) begin
      nxt = '{default: 0};
      bcount = 0;
    end else if (bus.FLUSH || (!bus.HOLD && (hz || !bus.ID_VALID))) begin
      nxt.valid = 0; nxt.ld = 0; nxt.st = 0; nxt.we = 0; nxt.sel = 0; nxt.rd = 0;
      if (!bus.FLUSH && hz) bcount = bcount + 1;
    end else if (!bus.HOLD) begin
      nxt = '{valid: 1, ld: bus.ID_MEM_READ, st: bus.ID_MEM_WRITE,
              we: bus.ID_REG_WRITE, op1pc: bus.ID_OP1_PC, op2imm: bus.ID_OP2_IMM,
              sel: bus.ID_ALU_SELECT, rd: bus.ID_RD_ADDR,
              rs1: bus.ID_RS1_ADDR, rs2: bus.ID_RS2_ADDR, pc: bus.ID_PC,
              a: bus.ID_RS1_DATA, b: bus.ID_RS2_DATA, imm: bus.ID_IMM};
    end
    @(posedge clk);
    ex = nxt;
    #1;
  endtask

  task automatic idle_inputs();
    bus.ID_VALID = 0; bus.ID_PC = 0; bus.ID_RS1_DATA = 0; bus.ID_RS2_DATA = 0;
    bus.ID_IMM = 0; bus.ID_RS1_ADDR = 0; bus.ID_RS2_ADDR = 0; bus.ID_RD_ADDR = 0;
    bus.ID_ALU_SELECT = ALU_ADD; bus.ID_OP1_PC = 0; bus.ID_OP2_IMM = 0;
    bus.ID_MEM_READ = 0; bus.ID_MEM_WRITE = 0; bus.ID_REG_WRITE = 0;
    bus.MEM_RD_ADDR = 0; bus.MEM_REG_WRITE = 0; bus.MEM_RESULT = 0;
    bus.WB_RD_ADDR = 0; bus.WB_REG_WRITE = 0; bus.WB_RESULT = 0;
    bus.FLUSH = 0; bus.HOLD = 0;
  endtask

  task automatic set_id(input bit [4:0] rs1, input bit [31:0] a, input bit [4:0] rs2,
                        input bit [31:0] b, input bit [4:0] rd, input bit [4:0] sel,
                        input bit ld, input bit [31:0] pc);
    bus.ID_VALID = 1; bus.ID_RS1_ADDR = rs1; bus.ID_RS1_DATA = a;
    bus.ID_RS2_ADDR = rs2; bus.ID_RS2_DATA = b; bus.ID_RD_ADDR = rd;
    bus.ID_ALU_SELECT = sel; bus.ID_MEM_READ = ld; bus.ID_MEM_WRITE = 0;
    bus.ID_REG_WRITE = 1; bus.ID_PC = pc; bus.ID_OP1_PC = 0; bus.ID_OP2_IMM = 0;
    bus.ID_IMM = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    #1;
    n_cmp++; if (bus.EX_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", bus.EX_VALID); end
    n_cmp++; if (bus.SELECT !== 5'd0) begin n_bad++; $display("FAIL reset_select got %0h want 0", bus.SELECT); end
    n_cmp++; if (bus.EX_PC !== 32'd0) begin n_bad++; $display("FAIL reset_pc got %0h want 0", bus.EX_PC); end
    n_cmp++; if (bus.DATA1 !== 32'd0 || bus.DATA2 !== 32'd0) begin n_bad++; $display("FAIL reset_data got %0h/%0h want 0/0", bus.DATA1, bus.DATA2); end
    n_cmp++; if (bus.BUBBLE_COUNT !== 32'd0) begin n_bad++; $display("FAIL reset_count got %0h want 0", bus.BUBBLE_COUNT); end
    n_cmp++; if (bus.STALL !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %0b want 0", bus.STALL); end
  endtask

  task automatic test_basic();
    set_id(5'd5, 32'd10, 5'd6, 32'd3, 5'd7, ALU_SUB, 0, 32'h100);
    cycle();
    bus.ID_VALID = 0;
    #1;
    n_cmp++; if (bus.DATA1 !== 32'd10) begin n_bad++; $display("FAIL basic_d1 got %0d want 10", bus.DATA1); end
    n_cmp++; if (bus.DATA2 !== 32'd3) begin n_bad++; $display("FAIL basic_d2 got %0d want 3", bus.DATA2); end
    n_cmp++; if (bus.SELECT !== 5'b00010) begin n_bad++; $display("FAIL basic_select got %b want 00010", bus.SELECT); end
    n_cmp++; if (bus.EX_VALID !== 1'b1 || bus.EX_RD_ADDR !== 5'd7) begin n_bad++; $display("FAIL basic_ctrl got v=%0b rd=%0d want v=1 rd=7", bus.EX_VALID, bus.EX_RD_ADDR); end
    cycle();
  endtask

  task automatic test_forwarding();
    set_id(5'd5, 32'h11, 5'd6, 32'd3, 5'd9, ALU_ADD, 0, 32'h104);
    cycle();
    bus.ID_VALID = 0;
    bus.MEM_REG_WRITE = 1; bus.MEM_RD_ADDR = 5; bus.MEM_RESULT = 32'h55;
    bus.WB_REG_WRITE = 1;  bus.WB_RD_ADDR = 5;  bus.WB_RESULT = 32'h77;
    #1;
    n_cmp++; if (bus.DATA1 !== 32'h55) begin n_bad++; $display("FAIL fwd_mem_wins got %0h want 55", bus.DATA1); end
    bus.MEM_REG_WRITE = 0;
    #1;
    n_cmp++; if (bus.DATA1 !== 32'h77) begin n_bad++; $display("FAIL fwd_wb got %0h want 77", bus.DATA1); end
    bus.MEM_REG_WRITE = 1; bus.MEM_RD_ADDR = 0; bus.WB_RD_ADDR = 0;
    set_id(5'd0, 32'h99, 5'd6, 32'd3, 5'd9, ALU_ADD, 0, 32'h108);
    bus.ID_OP2_IMM = 1; bus.ID_IMM = 32'h40;
    cycle();
    bus.ID_VALID = 0;
    #1;
    n_cmp++; if (bus.DATA1 !== 32'h99) begin n_bad++; $display("FAIL fwd_x0 got %0h want 99", bus.DATA1); end
    bus.MEM_RD_ADDR = 6; bus.MEM_RESULT = 32'hAB;
    #1;
    n_cmp++; if (bus.DATA2 !== 32'h40 || bus.EX_STORE_DATA !== 32'hAB) begin n_bad++; $display("FAIL fwd_store got d2=%0h sd=%0h want 40/ab", bus.DATA2, bus.EX_STORE_DATA); end
    idle_inputs();
    cycle();
  endtask

  task automatic test_load_use();
    bit [31:0] c0;
    c0 = bcount;
    set_id(5'd2, 32'h0, 5'd0, 32'h0, 5'd7, ALU_ADD, 1, 32'h200);
    cycle();
    set_id(5'd7, 32'h0, 5'd1, 32'h0, 5'd8, ALU_ADD, 0, 32'h204);
    #1;
    n_cmp++; if (bus.STALL !== 1'b1) begin n_bad++; $display("FAIL lu_stall got %0b want 1", bus.STALL); end
    cycle();
    n_cmp++; if (bus.EX_VALID !== 1'b0 || bus.BUBBLE_COUNT !== c0 + 1) begin n_bad++; $display("FAIL lu_bubble got v=%0b cnt=%0h want v=0 cnt=%0h", bus.EX_VALID, bus.BUBBLE_COUNT, c0 + 1); end
    n_cmp++; if (bus.STALL !== 1'b0) begin n_bad++; $display("FAIL lu_release got %0b want 0", bus.STALL); end
    cycle();
    n_cmp++; if (bus.EX_VALID !== 1'b1 || bus.EX_RD_ADDR !== 5'd8) begin n_bad++; $display("FAIL lu_capture got v=%0b rd=%0d want v=1 rd=8", bus.EX_VALID, bus.EX_RD_ADDR); end
    idle_inputs();
    cycle();
  endtask

  task automatic test_flush_hold();
    bit [31:0] c0;
    c0 = bcount;
    set_id(5'd1, 32'h1, 5'd2, 32'h2, 5'd3, ALU_XOR, 0, 32'h300);
    cycle();
    bus.FLUSH = 1; bus.HOLD = 1;
    cycle();
    n_cmp++; if (bus.EX_VALID !== 1'b0 || bus.BUBBLE_COUNT !== c0) begin n_bad++; $display("FAIL flush_hold got v=%0b cnt=%0h want v=0 cnt=%0h", bus.EX_VALID, bus.BUBBLE_COUNT, c0); end
    bus.FLUSH = 0; bus.HOLD = 0;
    set_id(5'd4, 32'h4, 5'd5, 32'h5, 5'd9, ALU_OR, 0, 32'h310);
    cycle();
    set_id(5'd6, 32'h6, 5'd7, 32'h7, 5'd10, ALU_AND, 0, 32'h320);
    bus.HOLD = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++; if (bus.EX_PC !== 32'h310 || bus.EX_RD_ADDR !== 5'd9 || bus.SELECT !== 5'b11000 || bus.EX_VALID !== 1'b1) begin
        n_bad++; $display("FAIL hold_%0d got pc=%0h rd=%0d sel=%b v=%0b want 310/9/11000/1", i, bus.EX_PC, bus.EX_RD_ADDR, bus.SELECT, bus.EX_VALID);
      end
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_wrap_and_reset();
    @(negedge clk);
    force dut.bubble_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.bubble_count_q;
    bcount = 32'hFFFF_FFFF;
    set_id(5'd2, 32'h0, 5'd0, 32'h0, 5'd7, ALU_ADD, 1, 32'h400);
    cycle();
    set_id(5'd1, 32'h0, 5'd7, 32'h0, 5'd8, ALU_ADD, 0, 32'h404);
    cycle();
    n_cmp++; if (bus.BUBBLE_COUNT !== 32'd0) begin n_bad++; $display("FAIL wrap got %0h want 0", bus.BUBBLE_COUNT); end
    set_id(5'd2, 32'h0, 5'd0, 32'h0, 5'd3, ALU_ADD, 1, 32'h500);
    cycle();
    set_id(5'd3, 32'h0, 5'd0, 32'h0, 5'd4, ALU_ADD, 0, 32'h504);
    #1;
    n_cmp++; if (bus.STALL !== 1'b1) begin n_bad++; $display("FAIL rst_pre_stall got %0b want 1", bus.STALL); end
    rst = 1;
    cycle();
    rst = 0;
    #1;
    n_cmp++; if (bus.EX_VALID !== 1'b0 || bus.EX_MEM_READ !== 1'b0 || bus.EX_REG_WRITE !== 1'b0 || bus.EX_RD_ADDR !== 5'd0 || bus.SELECT !== 5'd0) begin
      n_bad++; $display("FAIL rst_ctrl got v=%0b ld=%0b we=%0b rd=%0d sel=%0h want all 0", bus.EX_VALID, bus.EX_MEM_READ, bus.EX_REG_WRITE, bus.EX_RD_ADDR, bus.SELECT);
    end
    n_cmp++; if (bus.STALL !== 1'b0 || bus.BUBBLE_COUNT !== 32'd0 || bus.EX_PC !== 32'd0 || bus.DATA1 !== 32'd0 || bus.DATA2 !== 32'd0) begin
      n_bad++; $display("FAIL rst_data got st=%0b cnt=%0h pc=%0h d1=%0h d2=%0h want all 0", bus.STALL, bus.BUBBLE_COUNT, bus.EX_PC, bus.DATA1, bus.DATA2);
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.ID_VALID      = ($urandom_range(0, 9) < 8);
      bus.ID_PC         = $urandom;
      bus.ID_RS1_DATA   = $urandom;
      bus.ID_RS2_DATA   = $urandom;
      bus.ID_IMM        = $urandom;
      bus.ID_RS1_ADDR   = 5'($urandom_range(0, 7));
      bus.ID_RS2_ADDR   = 5'($urandom_range(0, 7));
      bus.ID_RD_ADDR    = 5'($urandom_range(0, 7));
      bus.ID_ALU_SELECT = 5'($urandom_range(0, 31));
      bus.ID_OP1_PC     = 1'($urandom_range(0, 1));
      bus.ID_OP2_IMM    = 1'($urandom_range(0, 1));
      bus.ID_MEM_READ   = ($urandom_range(0, 9) < 4);
      bus.ID_MEM_WRITE  = 1'($urandom_range(0, 1));
      bus.ID_REG_WRITE  = 1'($urandom_range(0, 1));
      bus.MEM_RD_ADDR   = 5'($urandom_range(0, 7));
      bus.MEM_REG_WRITE = 1'($urandom_range(0, 1));
      bus.MEM_RESULT    = $urandom;
      bus.WB_RD_ADDR    = 5'($urandom_range(0, 7));
      bus.WB_REG_WRITE  = 1'($urandom_range(0, 1));
      bus.WB_RESULT     = $urandom;
      bus.FLUSH         = ($urandom_range(0, 9) == 0);
      bus.HOLD          = ($urandom_range(0, 19) < 3);
      #1;
      n_cmp++; if (bus.STALL !== exp_stall()) begin n_bad++; $display("FAIL rnd_stall[%0d] got %0b want %0b", n, bus.STALL, exp_stall()); end
      n_cmp++; if (bus.EX_VALID !== ex.valid || bus.EX_MEM_READ !== ex.ld || bus.EX_MEM_WRITE !== ex.st ||
                   bus.EX_REG_WRITE !== ex.we || bus.SELECT !== ex.sel || bus.EX_RD_ADDR !== ex.rd) begin
        n_bad++; $display("FAIL rnd_ctrl[%0d] got v%0b r%0b w%0b g%0b s%0h d%0d want v%0b r%0b w%0b g%0b s%0h d%0d", n,
                          bus.EX_VALID, bus.EX_MEM_READ, bus.EX_MEM_WRITE, bus.EX_REG_WRITE, bus.SELECT, bus.EX_RD_ADDR,
                          ex.valid, ex.ld, ex.st, ex.we, ex.sel, ex.rd);
      end
      n_cmp++; if (bus.BUBBLE_COUNT !== bcount) begin n_bad++; $display("FAIL rnd_count[%0d] got %0h want %0h", n, bus.BUBBLE_COUNT, bcount); end
      if (ex.valid) begin
        n_cmp++; if (bus.DATA1 !== exp_d1() || bus.DATA2 !== exp_d2() || bus.EX_STORE_DATA !== fwd(ex.rs2, ex.b) || bus.EX_PC !== ex.pc) begin
          n_bad++; $display("FAIL rnd_data[%0d] got %0h %0h %0h %0h want %0h %0h %0h %0h", n,
                            bus.DATA1, bus.DATA2, bus.EX_STORE_DATA, bus.EX_PC, exp_d1(), exp_d2(), fwd(ex.rs2, ex.b), ex.pc);
        end
      end
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    ex = '{default: 0};
    bcount = 0;
    idle_inputs();
    test_reset();
    test_basic();
    test_forwarding();
    test_load_use();
    test_flush_hold();
    test_wrap_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
